ifetch_assoc: RTL and testbench

- Next-generation instruction fetch unit: parametrised set-associative I-cache with multi-word lines, bimodal branch predictor with parametrised BHT depth.
- Sits between the memory controller and the decoder. Issues at most one instruction per cycle toward dispatch.
- Accepts PC redirects and branch-outcome updates from the ROB.

---
 rtl/ifetch_assoc_pkg.sv | 22 ++
 rtl/ifetch_assoc_bht.sv | 40 ++++
 rtl/ifetch_assoc.sv | 206 ++++++++++++++++++++
 tb/tb_ifetch_assoc.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_assoc_pkg.sv
// Shared definitions for the set-associative instruction fetch unit:
// widths, RISC-V opcodes, refill FSM encodings and immediate decoders.
package ifetch_assoc_pkg;

    localparam int INST_W = 32;
    localparam int ADDR_W = 32;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;
    localparam logic [6:0] OPCODE_BR  = 7'b1100011;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    function automatic logic [ADDR_W-1:0] imm_b(input logic [INST_W-1:0] i_inst);
        return {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    endfunction

    function automatic logic [ADDR_W-1:0] imm_j(input logic [INST_W-1:0] i_inst);
        return {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifetch_assoc_bht.sv
// Bimodal branch history table: 2-bit saturating counters, one combinational
// read port for prediction and one registered update port from the ROB.
module bht_bimodal
    import ifetch_assoc_pkg::*;
#(
    parameter int SIZE  = 256,
    parameter int IDX_W = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [1:0]       o_rd_ctr,
    input  logic             i_upd_en,
    input  logic [IDX_W-1:0] i_upd_idx,
    input  logic             i_upd_taken
);

    logic [1:0] r_ctr [SIZE];

    // A same-cycle update is not forwarded: the read sees the pre-update count.
    assign o_rd_ctr = r_ctr[i_rd_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SIZE; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else if (i_en && i_upd_en) begin
            if (i_upd_taken) begin
                if (r_ctr[i_upd_idx] != 2'b11) begin
                    r_ctr[i_upd_idx] <= r_ctr[i_upd_idx] + 2'd1;
                end
            end else if (r_ctr[i_upd_idx] != 2'b00) begin
                r_ctr[i_upd_idx] <= r_ctr[i_upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/ifetch_assoc.sv
// Instruction fetch: set-associative I-cache with line refill FSM, bimodal
// branch prediction and single-instruction-per-cycle issue toward dispatch.
module ifetch_assoc
    import ifetch_assoc_pkg::*;
#(
    parameter int                SETS       = 64,
    parameter int                WAYS       = 2,
    parameter int                LINE_WORDS = 4,
    parameter int                BHT_SIZE   = 256,
    parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rdy,
    input  logic                         rs_nxt_full,
    input  logic                         lsb_nxt_full,
    input  logic                         rob_nxt_full,
    output logic                         inst_rdy,
    output logic [INST_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    output logic                         inst_pred_jump,
    output logic                         mc_en,
    output logic [ADDR_W-1:0]            mc_pc,
    input  logic                         mc_done,
    input  logic [LINE_WORDS*INST_W-1:0] mc_data,
    input  logic                         rob_set_pc_en,
    input  logic [ADDR_W-1:0]            rob_set_pc,
    input  logic                         rob_br,
    input  logic                         rob_br_jump,
    input  logic [ADDR_W-1:0]            rob_br_pc
);

    localparam int OFF       = 2 + $clog2(LINE_WORDS);
    localparam int OFF_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int IDX_W     = $clog2(SETS);
    localparam int TAG_W     = ADDR_W - OFF - IDX_W;
    localparam int LINE_W    = LINE_WORDS * INST_W;
    localparam int BHT_IDX_W = $clog2(BHT_SIZE);

    logic [ADDR_W-1:0] r_pc;
    logic [0:0]        r_state;
    logic              r_mc_en;
    logic [ADDR_W-1:0] r_mc_pc;
    logic              r_inst_rdy;
    logic [INST_W-1:0] r_inst;
    logic [ADDR_W-1:0] r_inst_pc;
    logic              r_inst_pred_jump;

    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_lru;
    logic [TAG_W-1:0]  r_tag   [WAYS][SETS];
    logic [LINE_W-1:0] r_data  [WAYS][SETS];

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [OFF_W-1:0]  w_off;
    logic              w_hit;
    logic              w_hit_way;
    logic [LINE_W-1:0] w_line;
    logic [INST_W-1:0] w_word;
    logic [1:0]        w_bht_ctr;
    logic [ADDR_W-1:0] w_pred_pc;
    logic              w_pred_jump;
    logic              w_issue;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_fill;
    logic              w_victim;
    logic              w_unused_ok;

    assign w_idx = r_pc[OFF +: IDX_W];
    assign w_tag = r_pc[ADDR_W-1 -: TAG_W];
    assign w_off = (LINE_WORDS > 1) ? r_pc[2 +: OFF_W] : '0;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = 1'b0;
        w_line    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_hit && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = 1'(w);
                w_line    = r_data[w][w_idx];
            end
        end
    end

    assign w_word = w_line[32'(w_off) * INST_W +: INST_W];

    bht_bimodal #(
        .SIZE  (BHT_SIZE),
        .IDX_W (BHT_IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (rdy),
        .i_rd_idx    (r_pc[BHT_IDX_W+1:2]),
        .o_rd_ctr    (w_bht_ctr),
        .i_upd_en    (rob_br),
        .i_upd_idx   (rob_br_pc[BHT_IDX_W+1:2]),
        .i_upd_taken (rob_br_jump)
    );

    // JALR is deliberately treated as sequential: its target needs a register value.
    always_comb begin
        w_pred_pc   = r_pc + 32'd4;
        w_pred_jump = 1'b0;
        if (w_word[6:0] == OPCODE_JAL) begin
            w_pred_pc   = r_pc + imm_j(w_word);
            w_pred_jump = 1'b1;
        end else if ((w_word[6:0] == OPCODE_BR) && w_bht_ctr[1]) begin
            w_pred_pc   = r_pc + imm_b(w_word);
            w_pred_jump = 1'b1;
        end
    end

    assign w_issue = w_hit && !rs_nxt_full && !lsb_nxt_full && !rob_nxt_full && !rob_set_pc_en;

    assign w_fill     = (r_state == ST_WAIT) && mc_done;
    assign w_fill_idx = r_mc_pc[OFF +: IDX_W];
    assign w_fill_tag = r_mc_pc[ADDR_W-1 -: TAG_W];

    // Victim is chosen in the refill set, which may differ from the current pc's set.
    always_comb begin
        w_victim = 1'b0;
        if (WAYS == 2) begin
            if (!r_valid[0][w_fill_idx]) begin
                w_victim = 1'b0;
            end else if (!r_valid[WAYS-1][w_fill_idx]) begin
                w_victim = 1'b1;
            end else begin
                w_victim = r_lru[w_fill_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_state          <= ST_IDLE;
            r_mc_en          <= 1'b0;
            r_mc_pc          <= '0;
            r_inst_rdy       <= 1'b0;
            r_inst           <= '0;
            r_inst_pc        <= '0;
            r_inst_pred_jump <= 1'b0;
            r_lru            <= '0;
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
            end
        end else if (rdy) begin
            r_inst_rdy <= w_issue;
            if (w_issue) begin
                r_inst           <= w_word;
                r_inst_pc        <= r_pc;
                r_inst_pred_jump <= w_pred_jump;
                r_pc             <= w_pred_pc;
                if (WAYS == 2) begin
                    r_lru[w_idx] <= ~w_hit_way;
                end
            end
            if (rob_set_pc_en) begin
                r_pc <= rob_set_pc;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_hit && !rob_set_pc_en) begin
                        r_mc_en <= 1'b1;
                        r_mc_pc <= {r_pc[ADDR_W-1:OFF], {OFF{1'b0}}};
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    if (w_fill) begin
                        r_valid[w_victim][w_fill_idx] <= 1'b1;
                        if (WAYS == 2) begin
                            r_lru[w_fill_idx] <= ~w_victim;
                        end
                        r_mc_en <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone qualify every hit.
    always_ff @(posedge clk) begin
        if (rdy && w_fill) begin
            r_tag[w_victim][w_fill_idx]  <= w_fill_tag;
            r_data[w_victim][w_fill_idx] <= mc_data;
        end
    end

    assign w_unused_ok = ^{rob_br_pc[ADDR_W-1:BHT_IDX_W+2], rob_br_pc[1:0]};

    assign inst_rdy       = r_inst_rdy;
    assign inst           = r_inst;
    assign inst_pc        = r_inst_pc;
    assign inst_pred_jump = r_inst_pred_jump;
    assign mc_en          = r_mc_en;
    assign mc_pc          = r_mc_pc;

endmodule

// File: tb/tb_ifetch_assoc.sv
// Directed bench for ifetch_assoc: refill, LRU eviction, branch prediction,
// redirects, back-pressure, freeze and asynchronous reset during a refill.
module tb_ifetch_assoc;

    localparam int LW = 4;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] BR_20  = 32'h0000_0863;  // beq x0,x0,+16
    localparam logic [31:0] JAL_40 = 32'h1000_006F;  // jal x0,+0x100

    logic             clk;
    logic             rst_n;
    logic             rdy;
    logic             rs_nxt_full;
    logic             lsb_nxt_full;
    logic             rob_nxt_full;
    logic             inst_rdy;
    logic [31:0]      inst;
    logic [31:0]      inst_pc;
    logic             inst_pred_jump;
    logic             mc_en;
    logic [31:0]      mc_pc;
    logic             mc_done;
    logic [LW*32-1:0] mc_data;
    logic             rob_set_pc_en;
    logic [31:0]      rob_set_pc;
    logic             rob_br;
    logic             rob_br_jump;
    logic [31:0]      rob_br_pc;

    int total = 0;
    int bad   = 0;

    ifetch_assoc #(
        .SETS       (64),
        .WAYS       (2),
        .LINE_WORDS (LW),
        .BHT_SIZE   (256),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .rs_nxt_full    (rs_nxt_full),
        .lsb_nxt_full   (lsb_nxt_full),
        .rob_nxt_full   (rob_nxt_full),
        .inst_rdy       (inst_rdy),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_pred_jump (inst_pred_jump),
        .mc_en          (mc_en),
        .mc_pc          (mc_pc),
        .mc_done        (mc_done),
        .mc_data        (mc_data),
        .rob_set_pc_en  (rob_set_pc_en),
        .rob_set_pc     (rob_set_pc),
        .rob_br         (rob_br),
        .rob_br_jump    (rob_br_jump),
        .rob_br_pc      (rob_br_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h20:  return BR_20;
            32'h40:  return JAL_40;
            default: return NOP;
        endcase
    endfunction

    function automatic logic [LW*32-1:0] line_of(input logic [31:0] a);
        logic [LW*32-1:0] l;
        for (int w = 0; w < LW; w++) begin
            l[w*32 +: 32] = mem_word({a[31:4], 4'h0} + 32'(w * 4));
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_issue(input logic [31:0] pc, input logic pj);
        tick();
        check("issue_rdy", {31'd0, inst_rdy}, 32'd1);
        check("issue_pc", inst_pc, pc);
        check("issue_inst", inst, mem_word(pc));
        check("issue_pred_jump", {31'd0, inst_pred_jump}, {31'd0, pj});
    endtask

    task automatic wait_mc(input logic [31:0] exp);
        for (int i = 0; i < 16 && !mc_en; i++) begin
            tick();
        end
        check("mc_en_wait", {31'd0, mc_en}, 32'd1);
        check("mc_pc", mc_pc, exp);
    endtask

    task automatic serve();
        mc_done = 1'b1;
        mc_data = line_of(mc_pc);
        tick();
        mc_done = 1'b0;
        check("fill_mc_en_drop", {31'd0, mc_en}, 32'd0);
    endtask

    task automatic redirect(input logic [31:0] target);
        rob_set_pc_en = 1'b1;
        rob_set_pc    = target;
        tick();
        rob_set_pc_en = 1'b0;
        check("redirect_kills_issue", {31'd0, inst_rdy}, 32'd0);
    endtask

    task automatic bht_upd(input logic [31:0] pc, input logic taken);
        rob_br      = 1'b1;
        rob_br_pc   = pc;
        rob_br_jump = taken;
        tick();
        rob_br      = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        rdy = 1'b1;
        rs_nxt_full = 1'b0;
        lsb_nxt_full = 1'b0;
        rob_nxt_full = 1'b0;
        mc_done = 1'b0;
        mc_data = '0;
        rob_set_pc_en = 1'b0;
        rob_set_pc = '0;
        rob_br = 1'b0;
        rob_br_jump = 1'b0;
        rob_br_pc = '0;

        #1 rst_n = 1'b0;
        #1;
        check("rst_inst_rdy", {31'd0, inst_rdy}, 32'd0);
        check("rst_mc_en", {31'd0, mc_en}, 32'd0);
        check("rst_mc_pc", mc_pc, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_pred_jump", {31'd0, inst_pred_jump}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Cold start: request line 0, then four sequential issues.
        tick();
        check("cold_mc_en", {31'd0, mc_en}, 32'd1);
        check("cold_mc_pc", mc_pc, 32'h0);
        serve();
        check("cold_no_issue_on_fill", {31'd0, inst_rdy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_issue(32'(i * 4), 1'b0);
        end
        tick();
        check("line_end_gap", {31'd0, inst_rdy}, 32'd0);
        check("next_line_mc_en", {31'd0, mc_en}, 32'd1);
        check("next_line_mc_pc", mc_pc, 32'h10);
        serve();
        for (int i = 0; i < 4; i++) begin
            expect_issue(32'h10 + 32'(i * 4), 1'b0);
        end

        // Branch at 0x20: not taken first, taken after one update.
        wait_mc(32'h20);
        serve();
        expect_issue(32'h20, 1'b0);
        expect_issue(32'h24, 1'b0);
        rob_set_pc_en = 1'b1;
        rob_set_pc = 32'h20;
        rob_br = 1'b1;
        rob_br_jump = 1'b1;
        rob_br_pc = 32'h20;
        tick();
        rob_set_pc_en = 1'b0;
        rob_br = 1'b0;
        check("redirect_with_hit", {31'd0, inst_rdy}, 32'd0);
        expect_issue(32'h20, 1'b1);
        wait_mc(32'h30);
        serve();
        for (int i = 0; i < 4; i++) begin
            expect_issue(32'h30 + 32'(i * 4), 1'b0);
        end

        // Saturation: three more taken then one not-taken leaves the counter at 2.
        wait_mc(32'h40);
        bht_upd(32'h20, 1'b1);
        bht_upd(32'h20, 1'b1);
        bht_upd(32'h20, 1'b1);
        bht_upd(32'h20, 1'b0);
        check("wait_hold_mc_en", {31'd0, mc_en}, 32'd1);
        check("wait_hold_mc_pc", mc_pc, 32'h40);
        serve();
        expect_issue(32'h40, 1'b1);
        wait_mc(32'h140);
        serve();
        expect_issue(32'h140, 1'b0);
        redirect(32'h20);
        expect_issue(32'h20, 1'b1);

        // Redirect during WAIT: refill of 0x400 completes, then 0x200 is requested.
        redirect(32'h400);
        tick();
        check("req_400_mc_en", {31'd0, mc_en}, 32'd1);
        check("req_400_mc_pc", mc_pc, 32'h400);
        rob_set_pc_en = 1'b1;
        rob_set_pc = 32'h200;
        tick();
        rob_set_pc_en = 1'b0;
        check("wait_redirect_mc_en", {31'd0, mc_en}, 32'd1);
        check("wait_redirect_mc_pc", mc_pc, 32'h400);
        serve();
        tick();
        check("rereq_mc_en", {31'd0, mc_en}, 32'd1);
        check("rereq_mc_pc", mc_pc, 32'h200);
        serve();
        expect_issue(32'h200, 1'b0);

        // Conflict line 0x800 evicts the LRU way (0x000) of set 0.
        redirect(32'h800);
        wait_mc(32'h800);
        serve();
        expect_issue(32'h800, 1'b0);
        rob_nxt_full = 1'b1;
        tick();
        check("rob_full_stall", {31'd0, inst_rdy}, 32'd0);
        tick();
        check("rob_full_stall2", {31'd0, inst_rdy}, 32'd0);
        check("rob_full_no_req", {31'd0, mc_en}, 32'd0);
        rob_nxt_full = 1'b0;
        expect_issue(32'h804, 1'b0);
        lsb_nxt_full = 1'b1;
        tick();
        check("lsb_full_stall", {31'd0, inst_rdy}, 32'd0);
        lsb_nxt_full = 1'b0;
        expect_issue(32'h808, 1'b0);
        rdy = 1'b0;
        tick();
        tick();
        check("freeze_inst_rdy", {31'd0, inst_rdy}, 32'd1);
        check("freeze_inst_pc", inst_pc, 32'h808);
        rdy = 1'b1;
        rs_nxt_full = 1'b1;
        tick();
        check("rs_full_stall", {31'd0, inst_rdy}, 32'd0);
        rs_nxt_full = 1'b0;
        expect_issue(32'h80C, 1'b0);
        redirect(32'h400);
        check("redirect_blocks_req", {31'd0, mc_en}, 32'd0);
        expect_issue(32'h400, 1'b0);
        check("refetch_400_no_mc", {31'd0, mc_en}, 32'd0);
        redirect(32'h0);
        tick();
        check("evicted_0_mc_en", {31'd0, mc_en}, 32'd1);
        check("evicted_0_mc_pc", mc_pc, 32'h0);

        // Asynchronous reset in WAIT, then a stale mc_done while IDLE.
        rst_n = 1'b0;
        #1;
        check("async_rst_mc_en", {31'd0, mc_en}, 32'd0);
        check("async_rst_inst_rdy", {31'd0, inst_rdy}, 32'd0);
        @(posedge clk);
        #1;
        mc_done = 1'b1;
        mc_data = line_of(32'h0);
        rst_n = 1'b1;
        tick();
        mc_done = 1'b0;
        check("post_rst_mc_en", {31'd0, mc_en}, 32'd1);
        check("post_rst_mc_pc", mc_pc, 32'h0);
        tick();
        check("late_done_ignored", {31'd0, inst_rdy}, 32'd0);
        check("late_done_still_wait", {31'd0, mc_en}, 32'd1);
        serve();
        expect_issue(32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
